// File: rtl/fifo_access_arbiter.sv
// fifo_access_arbiter: round-robin access control for a shared FIFO core.
// NREQ writers and one reader compete for the FIFO. Each granted operation
// holds the FIFO strobe high for HOLD cycles and then low for GAP cycles.
// The FIFO core acts on the falling strobe edge, so every grant produces
// exactly one FIFO operation. Only one operation is in flight at a time.
// Optional feature: define FIFO_ACC_STATS_EN to build saturating 16-bit
// write/read completion counters on stat_wr/stat_rd. When it is undefined,
// both outputs are tied to zero.
module fifo_access_arbiter #(
    parameter int NREQ  = 2,
    parameter int DBITS = 3,
    parameter int HOLD  = 4,
    parameter int GAP   = 4
) (
    input  logic                  SYS_CLK,
    input  logic                  reset,
    input  logic [NREQ-1:0]       wr_req,
    input  logic [NREQ*DBITS-1:0] wr_data,
    output logic [NREQ-1:0]       wr_gnt,
    output logic [NREQ-1:0]       wr_done,
    input  logic                  rd_req,
    output logic                  rd_gnt,
    output logic                  rd_valid,
    output logic [DBITS-1:0]      rd_data,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    output logic                  fifo_wr,
    output logic                  fifo_rd,
    output logic [DBITS-1:0]      fifo_din,
    input  logic [DBITS-1:0]      fifo_dout,
    output logic                  busy,
    output logic [15:0]           stat_wr,
    output logic [15:0]           stat_rd
);

    // Slot NREQ is the reader; slots 0..NREQ-1 are the writers.
    localparam int NSLOT = NREQ + 1;
    localparam int PW    = $clog2(NSLOT);
    localparam int MAXHG = (HOLD > GAP) ? HOLD : GAP;
    localparam int CW    = $clog2(MAXHG + 1);
    localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD - 1);
    localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP - 1);
    localparam logic [PW-1:0] RD_SLOT   = PW'(NREQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STROBE = 2'd1,
        ST_SETTLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t            state_q,    state_d;
    logic [CW-1:0]     cnt_q,      cnt_d;
    logic [PW-1:0]     ptr_q,      ptr_d;
    logic [NREQ-1:0]   wr_gnt_q,   wr_gnt_d;
    logic [NREQ-1:0]   wr_done_q,  wr_done_d;
    logic              rd_gnt_q,   rd_gnt_d;
    logic              rd_valid_q, rd_valid_d;
    logic [DBITS-1:0]  rd_data_q,  rd_data_d;
    logic              fifo_wr_q,  fifo_wr_d;
    logic              fifo_rd_q,  fifo_rd_d;
    logic [DBITS-1:0]  fifo_din_q, fifo_din_d;
    logic              busy_q,     busy_d;

    logic [NSLOT-1:0]  elig_s;
    logic              found_s;
    logic [PW-1:0]     pick_s;
    logic [PW-1:0]     idx_s;
    int                sum_s;

    // Eligibility per slot and round-robin search starting after the pointer.
    always_comb begin
        elig_s  = '0;
        found_s = 1'b0;
        pick_s  = '0;
        idx_s   = '0;
        sum_s   = 0;
        for (int i = 0; i < NREQ; i++) begin
            elig_s[i] = wr_req[i] & ~fifo_full;
        end
        elig_s[NREQ] = rd_req & ~fifo_empty;
        for (int k = 1; k <= NSLOT; k++) begin
            sum_s = (int'(ptr_q) + k) % NSLOT;
            idx_s = PW'(sum_s);
            if (!found_s && elig_s[idx_s]) begin
                found_s = 1'b1;
                pick_s  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and next-output logic of the operation sequencer.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        wr_gnt_d   = wr_gnt_q;
        wr_done_d  = '0;
        rd_gnt_d   = rd_gnt_q;
        rd_valid_d = 1'b0;
        rd_data_d  = rd_data_q;
        fifo_wr_d  = fifo_wr_q;
        fifo_rd_d  = fifo_rd_q;
        fifo_din_d = fifo_din_q;
        busy_d     = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (found_s) begin
                    state_d = ST_STROBE;
                    cnt_d   = HOLD_LOAD;
                    ptr_d   = pick_s;
                    busy_d  = 1'b1;
                    if (pick_s == RD_SLOT) begin
                        rd_gnt_d  = 1'b1;
                        fifo_rd_d = 1'b1;
                    end else begin
                        fifo_wr_d = 1'b1;
                        for (int i = 0; i < NREQ; i++) begin
                            wr_gnt_d[i] = (pick_s == PW'(i));
                            if (pick_s == PW'(i)) begin
                                fifo_din_d = wr_data[i*DBITS +: DBITS];
                            end else begin
                                fifo_din_d = fifo_din_d;
                            end
                        end
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_STROBE: begin
                if (cnt_q == '0) begin
                    state_d   = ST_SETTLE;
                    cnt_d     = GAP_LOAD;
                    fifo_wr_d = 1'b0;
                    fifo_rd_d = 1'b0;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d   = ST_DONE;
                    cnt_d     = '0;
                    wr_done_d = wr_gnt_q;
                    if (rd_gnt_q) begin
                        rd_valid_d = 1'b1;
                        rd_data_d  = fifo_dout;
                    end else begin
                        rd_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                cnt_d    = '0;
                wr_gnt_d = '0;
                rd_gnt_d = 1'b0;
                busy_d   = 1'b0;
            end
            default: begin
                state_d   = ST_IDLE;
                cnt_d     = '0;
                wr_gnt_d  = '0;
                rd_gnt_d  = 1'b0;
                fifo_wr_d = 1'b0;
                fifo_rd_d = 1'b0;
                busy_d    = 1'b0;
            end
        endcase
    end

    // State, pointer and registered outputs with synchronous active-low reset.
    always_ff @(posedge SYS_CLK) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ptr_q      <= '0;
            wr_gnt_q   <= '0;
            wr_done_q  <= '0;
            rd_gnt_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
            fifo_wr_q  <= 1'b0;
            fifo_rd_q  <= 1'b0;
            fifo_din_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            wr_gnt_q   <= wr_gnt_d;
            wr_done_q  <= wr_done_d;
            rd_gnt_q   <= rd_gnt_d;
            rd_valid_q <= rd_valid_d;
            rd_data_q  <= rd_data_d;
            fifo_wr_q  <= fifo_wr_d;
            fifo_rd_q  <= fifo_rd_d;
            fifo_din_q <= fifo_din_d;
            busy_q     <= busy_d;
        end
    end

    assign wr_gnt   = wr_gnt_q;
    assign wr_done  = wr_done_q;
    assign rd_gnt   = rd_gnt_q;
    assign rd_valid = rd_valid_q;
    assign rd_data  = rd_data_q;
    assign fifo_wr  = fifo_wr_q;
    assign fifo_rd  = fifo_rd_q;
    assign fifo_din = fifo_din_q;
    assign busy     = busy_q;

`ifdef FIFO_ACC_STATS_EN
    logic [15:0] stat_wr_q, stat_wr_d;
    logic [15:0] stat_rd_q, stat_rd_d;

    // Saturating completion counters, bumped on the DONE cycle.
    always_comb begin
        stat_wr_d = stat_wr_q;
        stat_rd_d = stat_rd_q;
        if (state_q == ST_DONE) begin
            if ((wr_gnt_q != '0) && (stat_wr_q != 16'hFFFF)) begin
                stat_wr_d = stat_wr_q + 16'd1;
            end else begin
                stat_wr_d = stat_wr_q;
            end
            if (rd_gnt_q && (stat_rd_q != 16'hFFFF)) begin
                stat_rd_d = stat_rd_q + 16'd1;
            end else begin
                stat_rd_d = stat_rd_q;
            end
        end else begin
            stat_wr_d = stat_wr_q;
        end
    end

    // Counter registers, cleared by reset.
    always_ff @(posedge SYS_CLK) begin
        if (!reset) begin
            stat_wr_q <= 16'h0000;
            stat_rd_q <= 16'h0000;
        end else begin
            stat_wr_q <= stat_wr_d;
            stat_rd_q <= stat_rd_d;
        end
    end

    assign stat_wr = stat_wr_q;
    assign stat_rd = stat_rd_q;
`else
    assign stat_wr = 16'h0000;
    assign stat_rd = 16'h0000;
`endif

endmodule

// File: tb/tb_fifo_access_arbiter.sv
// Scoreboard bench for fifo_access_arbiter (default parameters).
module tb_fifo_access_arbiter;

    logic        SYS_CLK = 1'b0;
    logic        reset;
    logic [1:0]  wr_req;
    logic [5:0]  wr_data;
    logic [1:0]  wr_gnt;
    logic [1:0]  wr_done;
    logic        rd_req;
    logic        rd_gnt;
    logic        rd_valid;
    logic [2:0]  rd_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_wr;
    logic        fifo_rd;
    logic [2:0]  fifo_din;
    logic [2:0]  fifo_dout;
    logic        busy;
    logic [15:0] stat_wr;
    logic [15:0] stat_rd;

    fifo_access_arbiter dut (
        .SYS_CLK   (SYS_CLK),
        .reset     (reset),
        .wr_req    (wr_req),
        .wr_data   (wr_data),
        .wr_gnt    (wr_gnt),
        .wr_done   (wr_done),
        .rd_req    (rd_req),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .fifo_full (fifo_full),
        .fifo_empty(fifo_empty),
        .fifo_wr   (fifo_wr),
        .fifo_rd   (fifo_rd),
        .fifo_din  (fifo_din),
        .fifo_dout (fifo_dout),
        .busy      (busy),
        .stat_wr   (stat_wr),
        .stat_rd   (stat_rd)
    );

    always #5 SYS_CLK = ~SYS_CLK;

    typedef struct packed {
        logic [1:0] wr;
        logic       rd;
        logic [2:0] d;
    } ev_t;

    ev_t gq[$];
    ev_t dq[$];
    int  errors = 0;
    int  checks = 0;
    logic busy_prev = 1'b0;

`ifdef FIFO_ACC_STATS_EN
    localparam logic [15:0] EXP_WR = 16'd6;
    localparam logic [15:0] EXP_RD = 16'd3;
`else
    localparam logic [15:0] EXP_WR = 16'd0;
    localparam logic [15:0] EXP_RD = 16'd0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge SYS_CLK);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < bound) begin
            tick();
            n++;
        end
        check("wait_idle", {31'd0, busy}, 32'd0);
    endtask

    // Monitor: grant start and completion events popped from the scoreboard.
    always @(negedge SYS_CLK) begin
        ev_t e;
        if (busy === 1'b1 && busy_prev === 1'b0) begin
            if (gq.size() == 0) begin
                check("unexpected_grant", {26'd0, wr_gnt, rd_gnt, fifo_din}, 32'd0);
            end else begin
                e = gq.pop_front();
                check("grant", {26'd0, wr_gnt, rd_gnt, (wr_gnt != 2'b00) ? fifo_din : 3'b000},
                      {26'd0, e.wr, e.rd, e.d});
            end
        end
        if (wr_done !== 2'b00 || rd_valid !== 1'b0) begin
            if (dq.size() == 0) begin
                check("unexpected_done", {26'd0, wr_done, rd_valid, rd_data}, 32'd0);
            end else begin
                e = dq.pop_front();
                check("done", {26'd0, wr_done, rd_valid, e.rd ? rd_data : 3'b000},
                      {26'd0, e.wr, e.rd, e.d});
            end
        end
        busy_prev <= busy;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  ngr;
        logic prev;
        reset      = 1'b0;
        wr_req     = 2'b11;
        wr_data    = {3'b110, 3'b001};
        rd_req     = 1'b0;
        fifo_full  = 1'b0;
        fifo_empty = 1'b0;
        fifo_dout  = 3'b000;

        // Reset held for 3 cycles with both writers requesting.
        tick(); tick(); tick();
        check("rst_gnt",   {29'd0, wr_gnt, rd_gnt}, 32'd0);
        check("rst_strobe", {30'd0, fifo_wr, fifo_rd}, 32'd0);
        check("rst_done",  {29'd0, wr_done, rd_valid}, 32'd0);
        check("rst_data",  {26'd0, rd_data, fifo_din}, 32'd0);
        check("rst_busy",  {31'd0, busy}, 32'd0);
        check("rst_stats", {stat_wr, stat_rd}, 32'd0);

        // First grant after release goes to writer 1.
        gq.push_back('{wr: 2'b10, rd: 1'b0, d: 3'b110});
        dq.push_back('{wr: 2'b10, rd: 1'b0, d: 3'b000});
        reset = 1'b1;
        tick();
        wr_req = 2'b00;
        check("first_gnt", {30'd0, wr_gnt}, 32'd2);
        wait_idle(20);

        // Single write: strobe timing and fifo_din stability.
        wr_data = {3'b010, 3'b101};
        gq.push_back('{wr: 2'b01, rd: 1'b0, d: 3'b101});
        dq.push_back('{wr: 2'b01, rd: 1'b0, d: 3'b000});
        wr_req = 2'b01;
        tick();
        wr_req  = 2'b00;
        wr_data = {3'b010, 3'b000};
        for (int c = 1; c <= 4; c++) begin
            check("hold_phase", {27'd0, fifo_wr, fifo_rd, fifo_din}, {27'd0, 1'b1, 1'b0, 3'b101});
            tick();
        end
        for (int c = 5; c <= 8; c++) begin
            check("gap_phase", {25'd0, fifo_wr, wr_gnt, fifo_din}, {25'd0, 1'b0, 2'b01, 3'b101});
            tick();
        end
        check("done_t9", {30'd0, wr_done}, 32'd1);
        tick();
        check("idle_t10", {29'd0, busy, wr_gnt}, 32'd0);

        // Rotation: writer1, reader, writer0, twice.
        wr_data   = {3'b010, 3'b101};
        fifo_dout = 3'b100;
        for (int r = 0; r < 2; r++) begin
            gq.push_back('{wr: 2'b10, rd: 1'b0, d: 3'b010});
            gq.push_back('{wr: 2'b00, rd: 1'b1, d: 3'b000});
            gq.push_back('{wr: 2'b01, rd: 1'b0, d: 3'b101});
            dq.push_back('{wr: 2'b10, rd: 1'b0, d: 3'b000});
            dq.push_back('{wr: 2'b00, rd: 1'b1, d: 3'b100});
            dq.push_back('{wr: 2'b01, rd: 1'b0, d: 3'b000});
        end
        wr_req = 2'b11;
        rd_req = 1'b1;
        ngr  = 0;
        prev = busy;
        for (int c = 0; c < 200 && ngr < 6; c++) begin
            tick();
            if (busy && !prev) ngr++;
            prev = busy;
        end
        wr_req = 2'b00;
        rd_req = 1'b0;
        check("rotation_grants", ngr, 32'd6);
        wait_idle(20);

        // Full FIFO: writer skipped, reader served; flag changes mid-op ignored.
        fifo_full = 1'b1;
        fifo_dout = 3'b011;
        gq.push_back('{wr: 2'b00, rd: 1'b1, d: 3'b000});
        dq.push_back('{wr: 2'b00, rd: 1'b1, d: 3'b011});
        wr_req = 2'b01;
        rd_req = 1'b1;
        tick();
        check("full_skip", {29'd0, wr_gnt, rd_gnt}, 32'd1);
        wr_req    = 2'b00;
        rd_req    = 1'b0;
        fifo_full = 1'b0;
        wait_idle(20);
        fifo_dout = 3'b111;
        tick(); tick();
        check("rd_data_hold", {29'd0, rd_data}, 32'd3);

        // Empty FIFO with only a read request: nothing granted.
        fifo_empty = 1'b1;
        rd_req     = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            check("empty_no_gnt", {29'd0, busy, rd_gnt, fifo_rd}, 32'd0);
        end
        rd_req     = 1'b0;
        fifo_empty = 1'b0;
        tick();

        // Reset in the middle of a write.
        wr_data = {3'b010, 3'b111};
        gq.push_back('{wr: 2'b01, rd: 1'b0, d: 3'b111});
        wr_req = 2'b01;
        tick();
        wr_req = 2'b00;
        tick();
        tick();
        check("abort_strobe_on", {31'd0, fifo_wr}, 32'd1);
        check("stats_before_abort", {stat_wr, stat_rd}, {EXP_WR, EXP_RD});
        reset = 1'b0;
        tick();
        check("abort_strobe_off", {28'd0, fifo_wr, wr_gnt, busy}, 32'd0);
        check("abort_stats", {stat_wr, stat_rd}, 32'd0);
        reset = 1'b1;
        tick(); tick(); tick();
        check("scoreboard_empty", {gq.size(), dq.size()} , 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fifo_access_arbiter.md
Name: fifo_access_arbiter

Overview:
- Shares one SPI-side FIFO storage core between NREQ write requesters and one read consumer.
- The FIFO core samples its wr/rd strobes at half SYS_CLK rate and acts on strobe deassertion. This block therefore holds each strobe high for HOLD cycles, then low for GAP cycles, so exactly one FIFO operation occurs per grant.
- Sits between SPI/MBED front-ends and the FIFO core; one operation in flight at a time.

Parameters:
- NREQ, 2, number of write requesters (1..8)
- DBITS, 3, FIFO data width
- HOLD, 4, cycles strobe is held high (>=2)
- GAP, 4, cycles strobe is held low after HOLD before the next operation (>=2)

Ports:
- SYS_CLK  in  1  single system clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- wr_req  in  NREQ  per-requester write request (level)
- wr_data  in  NREQ*DBITS  requester i data at bits [i*DBITS +: DBITS]
- wr_gnt  out  NREQ  one-hot grant, high for the whole operation
- wr_done  out  NREQ  one-cycle pulse at operation end
- rd_req  in  1  consumer read request (level)
- rd_gnt  out  1  high for the whole read operation
- rd_valid  out  1  one-cycle pulse, rd_data valid
- rd_data  out  DBITS  captured FIFO output word
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- fifo_wr  out  1  FIFO write strobe
- fifo_rd  out  1  FIFO read strobe
- fifo_din  out  DBITS  FIFO write data
- fifo_dout  in  DBITS  FIFO read data
- busy  out  1  high whenever not IDLE
- stat_wr  out  16  write count (see Optional Feature)
- stat_rd  out  16  read count (see Optional Feature)

Behaviour:
- Reset (reset==0 at an edge): state=IDLE. All outputs 0: strobes, grants, done, rd_valid, rd_data, fifo_din, busy, stats. Round-robin pointer=0.
- Reset mid-operation aborts at the next edge; the strobe drops immediately. The FIFO sees a falling strobe edge only if its own logic is still running; this is system-level behaviour and is not the arbiter's concern.
- Slots: 0..NREQ-1 are writers, NREQ is the reader.
  - Writer i is eligible when wr_req[i] & ~fifo_full.
  - Reader is eligible when rd_req & ~fifo_empty.
- FSM states: IDLE, STROBE, SETTLE, DONE.
- IDLE (cycle T): pick the first eligible slot starting at pointer+1 (mod NREQ+1), wrapping. Flags are sampled only in IDLE. Ineligible requesters are skipped, not stalled.
  - If a slot is found: go to STROBE. Register the grant. Latch fifo_din <= wr_data slice for a writer.
  - Pointer <= chosen slot.
  - No eligible slot: stay in IDLE, no outputs.
- STROBE (cycles T+1..T+HOLD): fifo_wr or fifo_rd =1, grant held. fifo_din is stable; the requester may change wr_data after the grant.
- SETTLE (cycles T+HOLD+1..T+HOLD+GAP): strobe =0, grant held, fifo_din stable.
- DONE (cycle T+HOLD+GAP+1):
  - Grant held.
  - Writer: wr_done[i]=1.
  - Reader: rd_data <= fifo_dout and rd_valid=1 in the same cycle. rd_data holds until the next read.
  - Next state IDLE.
- Operation latency: HOLD+GAP+2 cycles from the IDLE decision to the next IDLE decision. The default is 10.
- A requester keeping req high after done is re-eligible. It only wins again after every other eligible slot has had a turn.
- A single counter, ceil(log2(max(HOLD,GAP)+1)) bits, is reloaded on each state entry.
- Simultaneous requests from all slots are served in strict rotation with no starvation.
- fifo_full or fifo_empty changing during an operation has no effect on the operation in progress.

Optional Feature:
- Macro FIFO_ACC_STATS_EN.
- Defined: stat_wr increments at each writer DONE and stat_rd at each reader DONE. Both are 16-bit, saturate at 16'hFFFF, and clear on reset.
- Undefined: stat_wr and stat_rd are tied to 0 and no counter logic is generated.

Test Plan:
- Reset held low 3 cycles with wr_req=2'b11 -> all outputs 0. First grant at IDLE after release goes to wr_gnt=2'b10 (pointer 0, search from 1).
- wr_req[0]=1, wr_data slice0=3'b101, defaults -> fifo_wr high exactly cycles T+1..T+4, low T+5..T+8. fifo_din=3'b101 throughout. wr_done[0] pulse at T+9.
- wr_req=2'b11 and rd_req=1, fifo not full/empty, held -> grant order repeats writer1, reader, writer0 with no slot served twice in a row.
- fifo_full=1, wr_req[0]=1, rd_req=1 -> reader granted, writer skipped. fifo_empty=1 with only rd_req -> no grant, busy=0.
- Read with fifo_dout=3'b011 during SETTLE -> rd_valid pulse at T+9 with rd_data=3'b011. rd_data is retained afterwards.
- reset driven low at T+3 of a write -> fifo_wr=0 and grants=0 at the next edge. With FIFO_ACC_STATS_EN, stat_wr is unchanged by the aborted write and cleared to 0.
